// File: rtl/fret_sampler_array.sv
// Samples NUM_LANES screen positions per video frame, classifies each pixel as
// pressed/released/unknown colour and debounces the result over FILTER_FRAMES frames.
module fret_sampler_array #(
  parameter int NUM_LANES     = 5,
  parameter int FILTER_FRAMES = 2,
  parameter int X_W           = 11,
  parameter int Y_W           = 10
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           Enable,
  input  logic                           HSyncPulse,
  input  logic                           VSyncPulse,
  input  logic                           VDE,
  input  logic [23:0]                    RGB,
  input  logic [7:0]                     Tolerance,
  input  logic [NUM_LANES*(X_W+Y_W)-1:0] Pos,
  input  logic [NUM_LANES*24-1:0]        OnColour,
  input  logic [NUM_LANES*24-1:0]        OffColour,
  output logic [NUM_LANES-1:0]           Press,
  output logic [NUM_LANES-1:0]           Sampled
);

  localparam int P_W = X_W + Y_W;
  localparam int C_W = 4;
  localparam logic [C_W-1:0] FILT = C_W'(FILTER_FRAMES);

  typedef enum logic [1:0] {CLS_NONE = 2'd0, CLS_ON = 2'd1, CLS_OFF = 2'd2} sampleClass_t;
  typedef enum logic {RELEASED = 1'b0, PRESSED = 1'b1} laneState_t;

  logic [X_W-1:0] xCnt;
  logic [Y_W-1:0] yCnt;
  logic           lineActive;

  function automatic logic withinTol(input logic [7:0] a, input logic [7:0] b,
                                     input logic [7:0] tol);
    logic [8:0] diff;
    if (a >= b) diff = {1'b0, a} - {1'b0, b};
    else        diff = {1'b0, b} - {1'b0, a};
    return diff <= {1'b0, tol};
  endfunction

  function automatic logic colourMatch(input logic [23:0] pix, input logic [23:0] target,
                                       input logic [7:0] tol);
    return withinTol(pix[23:16], target[23:16], tol) &&
           withinTol(pix[15:8],  target[15:8],  tol) &&
           withinTol(pix[7:0],   target[7:0],   tol);
  endfunction

  // Raster position tracking; a frame start overrides a coincident line start.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      xCnt       <= '0;
      yCnt       <= '0;
      lineActive <= 1'b0;
    end else if (VSyncPulse) begin
      xCnt       <= '0;
      yCnt       <= '0;
      lineActive <= 1'b0;
    end else if (HSyncPulse) begin
      xCnt <= '0;
      if (lineActive) begin
        if (yCnt != {Y_W{1'b1}}) yCnt <= yCnt + Y_W'(1);
        lineActive <= 1'b0;
      end
    end else if (VDE) begin
      lineActive <= 1'b1;
      if (xCnt != {X_W{1'b1}}) xCnt <= xCnt + X_W'(1);
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : gLane
    logic [X_W-1:0] laneX;
    logic [Y_W-1:0] laneY;
    logic [23:0]    onTarget;
    logic [23:0]    offTarget;
    logic           sampleHit;
    sampleClass_t   sampleClass;
    logic [C_W-1:0] onNext;
    logic [C_W-1:0] offNext;
    logic           hitReg;
    sampleClass_t   classReg;
    logic [C_W-1:0] onCnt;
    logic [C_W-1:0] offCnt;
    laneState_t     state;
    logic           pressReg;
    logic           sampledReg;

    assign laneX     = Pos[i*P_W +: X_W];
    assign laneY     = Pos[i*P_W + X_W +: Y_W];
    assign onTarget  = OnColour[i*24 +: 24];
    assign offTarget = OffColour[i*24 +: 24];
    assign sampleHit = VDE && !VSyncPulse && (xCnt == laneX) && (yCnt == laneY);

    // Pixel classification; the pressed colour wins when both match.
    always_comb begin
      if (colourMatch(RGB, onTarget, Tolerance))       sampleClass = CLS_ON;
      else if (colourMatch(RGB, offTarget, Tolerance)) sampleClass = CLS_OFF;
      else                                             sampleClass = CLS_NONE;
    end

    // Filter counts as they will be after this frame's sample is committed.
    always_comb begin
      onNext  = onCnt;
      offNext = offCnt;
      if (hitReg && classReg == CLS_ON) begin
        onNext  = (onCnt == FILT) ? onCnt : onCnt + C_W'(1);
        offNext = '0;
      end else if (hitReg && classReg == CLS_OFF) begin
        offNext = (offCnt == FILT) ? offCnt : offCnt + C_W'(1);
        onNext  = '0;
      end else begin
        onNext  = onCnt;
        offNext = offCnt;
      end
    end

    // Per-frame sample capture and hit report.
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        hitReg     <= 1'b0;
        classReg   <= CLS_NONE;
        sampledReg <= 1'b0;
      end else if (VSyncPulse) begin
        sampledReg <= hitReg;
        hitReg     <= 1'b0;
        classReg   <= CLS_NONE;
      end else if (sampleHit) begin
        hitReg   <= 1'b1;
        classReg <= sampleClass;
      end
    end

    // Debounce state machine, held cleared while disabled.
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        onCnt    <= '0;
        offCnt   <= '0;
        state    <= RELEASED;
        pressReg <= 1'b0;
      end else if (!Enable) begin
        onCnt    <= '0;
        offCnt   <= '0;
        state    <= RELEASED;
        pressReg <= 1'b0;
      end else if (VSyncPulse) begin
        onCnt  <= onNext;
        offCnt <= offNext;
        case (state)
          RELEASED: if (onNext == FILT) begin
            state    <= PRESSED;
            pressReg <= 1'b1;
          end
          PRESSED: if (offNext == FILT) begin
            state    <= RELEASED;
            pressReg <= 1'b0;
          end
          default: begin
            state    <= RELEASED;
            pressReg <= 1'b0;
          end
        endcase
      end
    end

    assign Press[i]   = pressReg;
    assign Sampled[i] = sampledReg;
  end

endmodule

// File: tb/tb_fret_sampler_array.sv
// Self-checking bench for fret_sampler_array: directed frames, a tolerance table
// and randomized frames against a frame-level reference model.
module tb_fret_sampler_array;
  localparam int NL = 5;
  localparam int F  = 2;

  logic           CLK = 1'b0;
  logic           RST, Enable, HSyncPulse, VSyncPulse, VDE;
  logic [23:0]    RGB;
  logic [7:0]     Tolerance;
  logic [NL*21-1:0] Pos;
  logic [NL*24-1:0] OnColour, OffColour;
  logic [NL-1:0]  Press, Sampled;

  fret_sampler_array #(.NUM_LANES(NL), .FILTER_FRAMES(F), .X_W(11), .Y_W(10)) dut (
    .CLK(CLK), .RST(RST), .Enable(Enable), .HSyncPulse(HSyncPulse), .VSyncPulse(VSyncPulse),
    .VDE(VDE), .RGB(RGB), .Tolerance(Tolerance), .Pos(Pos), .OnColour(OnColour),
    .OffColour(OffColour), .Press(Press), .Sampled(Sampled));

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  int          lx[NL], ly[NL];
  logic [23:0] onC[NL], offC[NL], lcol[NL];
  logic [NL-1:0] mPress, mSampled;
  int          mOn[NL], mOff[NL];

  typedef struct {
    logic [23:0] pix;
    logic [7:0]  tol;
    logic        expPress;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(string name, logic [NL-1:0] act, logic [NL-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic packLanes();
    for (int i = 0; i < NL; i++) begin
      Pos[i*21 +: 11]      = 11'(lx[i]);
      Pos[i*21 + 11 +: 10] = 10'(ly[i]);
      OnColour[i*24 +: 24]  = onC[i];
      OffColour[i*24 +: 24] = offC[i];
    end
  endtask

  task automatic modelReset();
    mPress = '0; mSampled = '0;
    for (int i = 0; i < NL; i++) begin mOn[i] = 0; mOff[i] = 0; end
  endtask

  function automatic int absd(int a, int b);
    return (a > b) ? a - b : b - a;
  endfunction

  function automatic bit near(logic [23:0] p, logic [23:0] t, int tol);
    for (int k = 0; k < 3; k++)
      if (absd(int'(p[8*k +: 8]), int'(t[8*k +: 8])) > tol) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [23:0] pixelAt(int x, int y);
    for (int i = 0; i < NL; i++)
      if (lx[i] == x && ly[i] == y) return lcol[i];
    return 24'h5A5A5A;
  endfunction

  // Frame-level reference: which lanes saw their pixel, and debounce by run length.
  task automatic modelCommit(int w, int h);
    for (int i = 0; i < NL; i++) begin
      bit hit;
      logic [23:0] p;
      hit = (lx[i] < w) && (ly[i] < h);
      mSampled[i] = hit;
      if (!Enable) begin
        mOn[i] = 0; mOff[i] = 0; mPress[i] = 1'b0;
      end else if (hit) begin
        p = pixelAt(lx[i], ly[i]);
        if (near(p, onC[i], int'(Tolerance))) begin
          mOn[i] = (mOn[i] + 1 > F) ? F : mOn[i] + 1;
          mOff[i] = 0;
          if (mOn[i] == F) mPress[i] = 1'b1;
        end else if (near(p, offC[i], int'(Tolerance))) begin
          mOff[i] = (mOff[i] + 1 > F) ? F : mOff[i] + 1;
          mOn[i] = 0;
          if (mOff[i] == F) mPress[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic drawLines(int w, int h);
    for (int l = 0; l < h; l++) begin
      HSyncPulse = 1'b1; VDE = 1'b0; tick();
      HSyncPulse = 1'b0; tick();
      for (int x = 0; x < w; x++) begin
        VDE = 1'b1; RGB = pixelAt(x, l); tick();
      end
      VDE = 1'b0; tick();
    end
  endtask

  task automatic commit(int w, int h, bit special);
    chk("pre_press", Press, mPress);
    modelCommit(w, h);
    VSyncPulse = 1'b1; HSyncPulse = special; VDE = special; RGB = onC[4];
    tick();
    VSyncPulse = 1'b0; HSyncPulse = 1'b0; VDE = 1'b0;
    chk("post_press", Press, mPress);
    chk("post_sampled", Sampled, mSampled);
  endtask

  task automatic frame(int w, int h, bit special);
    drawLines(w, h);
    commit(w, h, special);
  endtask

  task automatic setEnable(bit e);
    Enable = e;
    if (!e) begin
      mPress = '0;
      for (int i = 0; i < NL; i++) begin mOn[i] = 0; mOff[i] = 0; end
    end
    tick();
    chk("enable_press", Press, mPress);
  endtask

  initial begin
    tbl[0] = '{pix: 24'hF0F0F0, tol: 8'd15,  expPress: 1'b0};
    tbl[1] = '{pix: 24'hF0F0F0, tol: 8'd15,  expPress: 1'b1};
    tbl[2] = '{pix: 24'hF0F0F0, tol: 8'd14,  expPress: 1'b1};
    tbl[3] = '{pix: 24'h0F0F0F, tol: 8'd15,  expPress: 1'b1};
    tbl[4] = '{pix: 24'hF0F0F0, tol: 8'd14,  expPress: 1'b1};
    tbl[5] = '{pix: 24'h0F0F0F, tol: 8'd15,  expPress: 1'b0};
    tbl[6] = '{pix: 24'h101010, tol: 8'd15,  expPress: 1'b0};
    tbl[7] = '{pix: 24'hF0F0F0, tol: 8'd255, expPress: 1'b0};
    tbl[8] = '{pix: 24'h808080, tol: 8'd128, expPress: 1'b1};
    tbl[9] = '{pix: 24'hFFFF00, tol: 8'd0,   expPress: 1'b1};

    RST = 1'b1; Enable = 1'b1; HSyncPulse = 1'b0; VSyncPulse = 1'b0; VDE = 1'b0;
    RGB = 24'h000000; Tolerance = 8'd0;
    lx   = '{100, 5, 7, 2000, 1};
    ly   = '{50, 3, 1, 900, 4};
    onC  = '{24'h00C000, 24'hFFFFFF, 24'h2040FF, 24'h3C3C3C, 24'hA0A000};
    offC = '{24'h400000, 24'h000000, 24'h101010, 24'hC3C3C3, 24'h0000A0};
    lcol = '{24'h00C000, 24'h000000, 24'h101010, 24'h3C3C3C, 24'hA0A000};
    packLanes();
    modelReset();
    repeat (2) tick();
    chk("reset_press", Press, 5'b00000);
    chk("reset_sampled", Sampled, 5'b00000);
    RST = 1'b0; tick();

    // Partial frame hits lane2, then an asynchronous reset must discard it.
    drawLines(8, 3);
    #2 RST = 1'b1;
    #1 chk("midframe_rst_press", Press, 5'b00000);
    tick(); RST = 1'b0;
    commit(0, 0, 1'b0);

    // Lane0 at (100,50) in 128x56 frames; lane3 far outside the active area.
    frame(128, 56, 1'b0);
    chk("lane0_f1_press", 5'(Press[0]), 5'd0);
    chk("lane0_f1_sampled", 5'(Sampled[0]), 5'd1);
    chk("lane3_f1_sampled", 5'(Sampled[3]), 5'd0);
    frame(128, 56, 1'b0);
    chk("lane0_f2_press", 5'(Press[0]), 5'd1);
    frame(128, 56, 1'b0);
    chk("lane0_f3_press", 5'(Press[0]), 5'd1);
    chk("lane3_f3_press", 5'(Press[3]), 5'd0);

    // Tolerance table on lane1 (on = FFFFFF, off = 000000).
    lx[0] = 3; ly[0] = 2;
    packLanes();
    for (int r = 0; r < 10; r++) begin
      lcol[1] = tbl[r].pix; Tolerance = tbl[r].tol;
      frame(10, 6, 1'b0);
      chk($sformatf("tbl%0d_press", r), 5'(Press[1]), 5'(tbl[r].expPress));
      chk($sformatf("tbl%0d_sampled", r), 5'(Sampled[1]), 5'd1);
    end

    // Lane2: press, then ON OFF ON OFF OFF releases only on the last frame.
    Tolerance = 8'd4;
    lcol[2] = onC[2];
    frame(10, 6, 1'b0); frame(10, 6, 1'b0);
    chk("lane2_pressed", 5'(Press[2]), 5'd1);
    for (int s = 0; s < 5; s++) begin
      lcol[2] = (s == 0 || s == 2) ? onC[2] : offC[2];
      frame(10, 6, 1'b0);
      chk($sformatf("lane2_seq%0d", s), 5'(Press[2]), (s == 4) ? 5'd0 : 5'd1);
    end

    // Enable low drops the press at once and forces a fresh debounce.
    frame(10, 6, 1'b0);
    chk("lane0_before_en", 5'(Press[0]), 5'd1);
    setEnable(1'b0);
    chk("lane0_en_low", 5'(Press[0]), 5'd0);
    frame(10, 6, 1'b0);
    chk("lane0_dis_frame", 5'(Press[0]), 5'd0);
    chk("lane0_dis_sampled", 5'(Sampled[0]), 5'd1);
    setEnable(1'b1);
    frame(10, 6, 1'b0);
    chk("lane0_reen_f1", 5'(Press[0]), 5'd0);
    frame(10, 6, 1'b0);
    chk("lane0_reen_f2", 5'(Press[0]), 5'd1);

    // Asynchronous reset mid-frame with lanes pressed.
    drawLines(10, 3);
    #2 RST = 1'b1;
    #1 chk("async_rst_press", Press, 5'b00000);
    chk("async_rst_sampled", Sampled, 5'b00000);
    modelReset();
    tick(); RST = 1'b0;
    commit(0, 0, 1'b0);

    // Coincident H/V sync with lane4's target pixel on the VSync cycle.
    lx[4] = 10; ly[4] = 5;
    packLanes();
    frame(10, 6, 1'b1);
    chk("hv_sampled4", 5'(Sampled[4]), 5'd0);
    frame(10, 6, 1'b0);
    chk("hv_next_sampled4", 5'(Sampled[4]), 5'd0);
    chk("hv_next_sampled0", 5'(Sampled[0]), 5'd1);

    // Randomized frames against the reference model.
    for (int i = 0; i < NL; i++) begin
      onC[i]  = 24'($urandom);
      offC[i] = onC[i] ^ 24'h808080;
    end
    for (int f = 0; f < 40; f++) begin
      int w, h;
      bit en;
      w = $urandom_range(3, 10);
      h = $urandom_range(2, 6);
      for (int i = 0; i < NL; i++) begin
        int k;
        lx[i] = $urandom_range(0, 11);
        ly[i] = $urandom_range(0, 7);
        if (i > 0 && ($urandom % 4) == 0) begin lx[i] = lx[i-1]; ly[i] = ly[i-1]; end
        k = $urandom % 4;
        case (k)
          0:       lcol[i] = onC[i] ^ (24'($urandom) & 24'h070707);
          1:       lcol[i] = offC[i] ^ (24'($urandom) & 24'h070707);
          2:       lcol[i] = 24'($urandom);
          default: lcol[i] = onC[i];
        endcase
      end
      Tolerance = 8'($urandom_range(0, 24));
      packLanes();
      en = ($urandom % 8) != 0;
      if (en != Enable) setEnable(en);
      frame(w, h, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
